// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the SoC memory-bus arbiter and bridges.
package mem_bus_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    // On a tie the master that did not own the bus last time wins.
    function automatic logic pick_owner(
        input logic v0,
        input logic v1,
        input logic last
    );
        if (v0 && v1) begin
            return ~last;
        end
        return v1 ? M_AUX : M_CPU;
    endfunction

    function automatic logic [1:0] owner_onehot(input logic idx);
        return (idx == M_AUX) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall counter: counts enabled cycles and flags expiry at LIMIT-1.
// Saturates at the limit so it can never wrap while the owner waits.
module bus_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count == LAST);
    assign o_expired  = i_enable && w_at_limit;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the valid/ready memory bus.
// One transaction per grant; stalled accesses complete with a fault.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,
    output logic                m0_fault,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,
    output logic                m1_fault,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,
    output logic [1:0]          grant
);
    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       r_last;
    logic       w_last_nxt;

    logic w_busy;
    logic w_own_valid;
    logic w_expired;
    logic w_done;
    logic w_fault;
    logic w_exit;

    assign w_busy      = (r_state == ARB_BUSY);
    assign w_own_valid = (r_owner == M_AUX) ? m1_valid : m0_valid;
    assign w_done      = w_busy && w_own_valid && (s_ready || w_expired);
    // A real slave answer beats a coincident timeout.
    assign w_fault     = w_done && !s_ready;
    assign w_exit      = w_busy && (!w_own_valid || s_ready || w_expired);

    bus_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_busy || w_exit),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_owner <= M_CPU;
            r_last  <= M_AUX;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        unique case (r_state)
            ARB_IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_state_nxt = ARB_BUSY;
                    w_owner_nxt = pick_owner(m0_valid, m1_valid, r_last);
                end
            end
            ARB_BUSY: begin
                if (w_exit) begin
                    w_state_nxt = ARB_IDLE;
                    w_last_nxt  = r_owner;
                end
            end
        endcase
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        grant    = 2'b00;
        m0_ready = 1'b0;
        m0_fault = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_fault = 1'b0;
        m1_rdata = '0;
        if (w_busy) begin
            grant   = owner_onehot(r_owner);
            s_valid = w_own_valid && !w_fault;
            if (r_owner == M_AUX) begin
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = w_done;
                m1_fault = w_fault;
                m1_rdata = (w_done && s_ready) ? s_rdata : '0;
            end else begin
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = w_done;
                m0_fault = w_fault;
                m0_rdata = (w_done && s_ready) ? s_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready, m0_fault, m1_fault;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [1:0]  grant;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m0_fault(m0_fault),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .m1_fault(m1_fault),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant)
    );

    task automatic idle_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        m0_valid = 1; m1_valid = 1; s_ready = 1; s_rdata = 32'hFFFF_FFFF;
        m0_addr = 32'h1111_1111; m1_addr = 32'h2222_2222;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({grant, s_valid, m0_ready, m1_ready, m0_fault, m1_fault} !== 6'b0) begin
            errs++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {grant, s_valid, m0_ready, m1_ready, m0_fault, m1_fault});
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata} !== 132'h0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0",
                     {s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata});
        end
        idle_inputs();
        reset = 0;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errs++;
            $display("FAIL reset_idle_grant: got %b want 00", grant);
        end
    endtask

    task automatic test_single_read();
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 0; m0_wdata = 0;
        #1;
        checks++;
        if ({grant, m0_ready, s_valid} !== 4'b0) begin
            errs++;
            $display("FAIL read_arb_cycle: got %b want 0000", {grant, m0_ready, s_valid});
        end
        @(negedge clk);
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({grant, s_valid, s_addr, s_wstrb} !== {2'b01, 1'b1, 32'h10, 4'h0}) begin
            errs++;
            $display("FAIL read_bus: got %h want %h",
                     {grant, s_valid, s_addr, s_wstrb}, {2'b01, 1'b1, 32'h10, 4'h0});
        end
        checks++;
        if ({m0_ready, m0_fault, m0_rdata, m1_ready, m1_rdata} !==
            {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
            errs++;
            $display("FAIL read_resp: got %h want %h",
                     {m0_ready, m0_fault, m0_rdata, m1_ready, m1_rdata},
                     {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0});
        end
        @(negedge clk);
        m0_valid = 0; s_ready = 0;
        #1;
        checks++;
        if ({grant, m0_ready, m0_rdata} !== 35'h0) begin
            errs++;
            $display("FAIL read_after: got %h want 0", {grant, m0_ready, m0_rdata});
        end
    endtask

    task automatic test_write();
        int sv_cnt;
        sv_cnt = 0;
        m1_valid = 1; m1_addr = 32'h1200_0000;
        m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
        #1;
        sv_cnt += int'(s_valid);
        @(negedge clk);
        s_ready = 1; s_rdata = 32'h0BAD_0BAD;
        #1;
        sv_cnt += int'(s_valid);
        checks++;
        if ({grant, s_addr, s_wdata, s_wstrb} !==
            {2'b10, 32'h1200_0000, 32'h1234_5678, 4'b0011}) begin
            errs++;
            $display("FAIL write_bus: got %h want %h",
                     {grant, s_addr, s_wdata, s_wstrb},
                     {2'b10, 32'h1200_0000, 32'h1234_5678, 4'b0011});
        end
        checks++;
        if ({m1_ready, m1_fault, m0_ready} !== 3'b100) begin
            errs++;
            $display("FAIL write_resp: got %b want 100", {m1_ready, m1_fault, m0_ready});
        end
        @(negedge clk);
        m1_valid = 0; s_ready = 0;
        #1;
        sv_cnt += int'(s_valid);
        @(negedge clk);
        #1;
        sv_cnt += int'(s_valid);
        checks++;
        if (sv_cnt !== 1) begin
            errs++;
            $display("FAIL write_svalid_len: got %0d want 1", sv_cnt);
        end
    endtask

    task automatic test_tie_rr();
        logic [1:0]  eg;
        logic [31:0] ea;
        do_reset();
        m0_valid = 1; m1_valid = 1;
        m0_addr = 32'hA000_0000; m1_addr = 32'hB000_0004;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_ready = 1; s_rdata = k;
            #1;
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            ea = (k % 2 == 1) ? 32'hB000_0004 : 32'hA000_0000;
            checks++;
            if ({grant, s_addr, m0_ready, m1_ready} !== {eg, ea, eg[0], eg[1]}) begin
                errs++;
                $display("FAIL tie_rr_%0d: got %h want %h", k,
                         {grant, s_addr, m0_ready, m1_ready}, {eg, ea, eg[0], eg[1]});
            end
            @(negedge clk);
            s_ready = 0;
            #1;
            checks++;
            if (grant !== 2'b00) begin
                errs++;
                $display("FAIL tie_idle_%0d: got %b want 00", k, grant);
            end
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        m0_valid = 1; m0_addr = 32'h2000_0000;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            s_ready = 0; s_rdata = 32'hCAFE_F00D;
            if (c == 5) begin
                m1_valid = 1; m1_addr = 32'h3000_0000;
            end
            #1;
            if (c < TO) begin
                checks++;
                if ({m0_ready, m0_fault, s_valid, grant} !== 5'b00101) begin
                    errs++;
                    $display("FAIL to_wait_%0d: got %b want 00101", c,
                             {m0_ready, m0_fault, s_valid, grant});
                end
            end else begin
                checks++;
                if ({m0_ready, m0_fault, m0_rdata, s_valid, m1_ready, m1_fault} !==
                    {2'b11, 32'h0, 3'b000}) begin
                    errs++;
                    $display("FAIL to_fault: got %h want %h",
                             {m0_ready, m0_fault, m0_rdata, s_valid, m1_ready, m1_fault},
                             {2'b11, 32'h0, 3'b000});
                end
            end
        end
        @(negedge clk);
        m0_valid = 0;
        #1;
        checks++;
        if ({grant, m0_ready, m1_ready} !== 4'b0) begin
            errs++;
            $display("FAIL to_idle: got %b want 0000", {grant, m0_ready, m1_ready});
        end
        @(negedge clk);
        s_ready = 1;
        #1;
        checks++;
        if ({grant, s_addr, m1_ready, m1_fault} !== {2'b10, 32'h3000_0000, 2'b10}) begin
            errs++;
            $display("FAIL to_next_m1: got %h want %h",
                     {grant, s_addr, m1_ready, m1_fault}, {2'b10, 32'h3000_0000, 2'b10});
        end
        @(negedge clk);
        m1_valid = 0; s_ready = 0;
    endtask

    task automatic test_coincide();
        m0_valid = 1; m0_addr = 32'h0000_0040;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            s_ready = (c == TO); s_rdata = 32'hA5A5_5A5A;
            #1;
            if (c == TO - 1) begin
                checks++;
                if (m0_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL co_early: got %b want 0", m0_ready);
                end
            end
            if (c == TO) begin
                checks++;
                if ({m0_ready, m0_fault, m0_rdata, s_valid} !=={2'b10, 32'hA5A5_5A5A, 1'b1}) begin
                    errs++;
                    $display("FAIL co_done: got %h want %h",
                             {m0_ready, m0_fault, m0_rdata, s_valid},
                             {2'b10, 32'hA5A5_5A5A, 1'b1});
                end
            end
        end
        @(negedge clk);
        m0_valid = 0; s_ready = 0;
    endtask

    task automatic test_reset_mid_busy();
        m0_valid = 1; m0_addr = 32'h0000_0050;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({m0_ready, s_valid} !== 2'b01) begin
                errs++;
                $display("FAIL rmb_stall_%0d: got %b want 01", c, {m0_ready, s_valid});
            end
        end
        reset = 1; m1_valid = 1; m1_addr = 32'h0000_0060;
        @(negedge clk);
        #1;
        checks++;
        if ({grant, s_valid, m0_ready, m1_ready, m0_fault, m1_fault} !== 6'b0) begin
            errs++;
            $display("FAIL rmb_after: got %b want 000000",
                     {grant, s_valid, m0_ready, m1_ready, m0_fault, m1_fault});
        end
        reset = 0;
        @(negedge clk);
        s_ready = 1; s_rdata = 32'h7777_0000;
        #1;
        checks++;
        if ({grant, s_addr, m0_ready, m1_ready} !== {2'b01, 32'h50, 2'b10}) begin
            errs++;
            $display("FAIL rmb_first_grant: got %h want %h",
                     {grant, s_addr, m0_ready, m1_ready}, {2'b01, 32'h50, 2'b10});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        int          own, age, lat, last;
        bit          req [2];
        bit          dprev [2];
        logic [31:0] a [2];
        logic [31:0] wd [2];
        logic [3:0]  ws [2];
        bit          done, flt;
        logic [67:0] exp_m, got_m;
        logic [68:0] exp_s, got_s;
        logic [1:0]  exp_g;
        do_reset();
        own = -1; age = 0; lat = 0; last = 1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; dprev[i] = 0; a[i] = 0; wd[i] = 0; ws[i] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (dprev[i]) begin
                    req[i] = 0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1;
                    a[i] = $urandom; wd[i] = $urandom; ws[i] = 4'($urandom);
                end
                dprev[i] = 0;
            end
            m0_valid = req[0]; m0_addr = a[0]; m0_wdata = wd[0]; m0_wstrb = ws[0];
            m1_valid = req[1]; m1_addr = a[1]; m1_wdata = wd[1]; m1_wstrb = ws[1];
            s_rdata = $urandom;
            s_ready = (own >= 0) ? (age == lat) : 1'($urandom_range(0, 1));
            #1;
            done = (own >= 0) && (age == lat || age == TO);
            flt  = (own >= 0) && (age == TO) && (age != lat);
            exp_m = '0;
            exp_s = '0;
            exp_g = 2'b00;
            if (own >= 0) begin
                exp_g = (own == 1) ? 2'b10 : 2'b01;
                exp_s = {!flt, a[own], wd[own], ws[own]};
                if (own == 0)
                    exp_m[67:34] = {done, flt, (done && !flt) ? s_rdata : 32'h0};
                else
                    exp_m[33:0] = {done, flt, (done && !flt) ? s_rdata : 32'h0};
            end
            got_m = {m0_ready, m0_fault, m0_rdata, m1_ready, m1_fault, m1_rdata};
            got_s = {s_valid, s_addr, s_wdata, s_wstrb};
            checks++;
            if (got_m !== exp_m) begin
                errs++;
                $display("FAIL rnd_master c=%0d: got %h want %h", c, got_m, exp_m);
            end
            checks++;
            if (got_s !== exp_s) begin
                errs++;
                $display("FAIL rnd_slave c=%0d: got %h want %h", c, got_s, exp_s);
            end
            checks++;
            if (grant !== exp_g) begin
                errs++;
                $display("FAIL rnd_grant c=%0d: got %b want %b", c, grant, exp_g);
            end
            if (own >= 0) begin
                if (done) begin
                    last = own;
                    dprev[own] = 1;
                    own = -1;
                end else begin
                    age++;
                end
            end else if (req[0] || req[1]) begin
                own = (req[0] && req[1]) ? 1 - last : (req[0] ? 0 : 1);
                age = 1;
                case ($urandom_range(0, 7))
                    0, 1, 2, 3: lat = $urandom_range(1, 4);
                    4:          lat = 7;
                    5:          lat = TO;
                    6:          lat = 99;
                    default:    lat = 2;
                endcase
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_single_read();
        test_write();
        test_tie_rr();
        test_timeout();
        test_coincide();
        test_reset_mid_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
